reg_file: RTL and testbench

- Architectural register file and zero-flag register for the single-cycle processor.
- Sits directly upstream of the ALU: it supplies the 8-bit InputA operand and the 1-bit InputB operand.
- It also consumes the ALU result and zero flag on the write-back path, closing the single-cycle datapath loop.
- Reads are combinational from registered state; writes and flag updates commit on the rising clock edge.

---
 rtl/reg_file_pkg.sv | 26 ++
 rtl/reg_file_if.sv | 33 +++
 rtl/reg_file_flag_reg.sv | 23 ++
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared processor definitions.
//   - Default datapath/address widths and the derived register count.
//   - Named register indices used by the decoder and the register file.
//   - ALU opcode enumeration.
package reg_file_pkg;

  localparam int unsigned RF_DW     = 8;
  localparam int unsigned RF_AW     = 3;
  localparam int unsigned REG_COUNT = 2 ** RF_AW;

  // Registers with a fixed role in the instruction set.
  localparam logic [RF_AW-1:0] REG_ACC  = 3'd0;
  localparam logic [RF_AW-1:0] REG_LOOP = 3'd6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_INC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_t;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read/write/flag signals of the register file.
//   master : datapath side (drives addresses, write-back data, flag update)
//   slave  : register file side (drives read data, BitOutB, ZeroFlag)
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
);

  logic [AW-1:0] RaddrA;
  logic [AW-1:0] RaddrB;
  logic          WriteEn;
  logic [AW-1:0] Waddr;
  logic [DW-1:0] DataIn;
  logic          FlagWrite;
  logic          ZeroIn;
  logic [DW-1:0] DataOutA;
  logic [DW-1:0] DataOutB;
  logic          BitOutB;
  logic          ZeroFlag;

  modport master (
    output RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWrite, ZeroIn,
    input  DataOutA, DataOutB, BitOutB, ZeroFlag
  );

  modport slave (
    input  RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWrite, ZeroIn,
    output DataOutA, DataOutB, BitOutB, ZeroFlag
  );

endinterface

// File: rtl/reg_file_flag_reg.sv
// reg_file_flag_reg: single condition-flag register (the zero flag today).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears q, overrides load
//   load : capture d on the next rising edge
//   d    : next flag value
//   q    : registered flag
module reg_file_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file plus zero flag.
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous active-high reset; clears all registers and the flag
//   rf    : slave side of reg_file_if
//     RaddrA/RaddrB -> DataOutA/DataOutB/BitOutB, combinational reads of
//                      registered state (no write-through bypass)
//     WriteEn/Waddr/DataIn -> register write on the rising edge
//     FlagWrite/ZeroIn     -> ZeroFlag update on the rising edge
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
) (
  input  logic     Clk,
  input  logic     Reset,
  reg_file_if.slave rf
);

  localparam int unsigned NREGS = 2 ** AW;

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else if (rf.WriteEn) begin
      regs[rf.Waddr] <= rf.DataIn;
    end
  end

  // Reads see the pre-edge contents, so an ALU operand read and the
  // write-back of its result can share one cycle and one address.
  always_comb begin
    rf.DataOutA = regs[rf.RaddrA];
    rf.DataOutB = regs[rf.RaddrB];
    rf.BitOutB  = rf.DataOutB[0];
  end

  reg_file_flag_reg u_zero_flag (
    .clk  (Clk),
    .rst  (Reset),
    .load (rf.FlagWrite),
    .d    (rf.ZeroIn),
    .q    (rf.ZeroFlag)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
module tb_reg_file;
  import reg_file_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 Clk = ~Clk;

  reg_file_if #(.DW(8), .AW(3)) rf ();

  reg_file #(.DW(8), .AW(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .rf    (rf)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    rf.WriteEn = 1'b1;
    rf.Waddr   = a;
    rf.DataIn  = d;
    tick();
    rf.WriteEn = 1'b0;
  endtask

  function automatic logic [7:0] alu_model(input alu_op_t op, input logic [7:0] a);
    case (op)
      ALU_INC: return a + 8'd1;
      default: return a;
    endcase
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int a = 1; a < 8; a++) wr(3'(a), 8'hA5);
    rf.FlagWrite = 1'b1; rf.ZeroIn = 1'b1;
    tick();
    rf.FlagWrite = 1'b0; rf.ZeroIn = 1'b0;
    rf.RaddrA = 3'd7; rf.RaddrB = 3'd1;
    @(negedge Clk);
    vectors++; if (rf.DataOutA !== 8'hA5) begin miscompares++; $display("FAIL preload_a: got %h want a5", rf.DataOutA); end
    vectors++; if (rf.ZeroFlag !== 1'b1) begin miscompares++; $display("FAIL preload_flag: got %b want 1", rf.ZeroFlag); end
    vectors++; if (rf.BitOutB !== 1'b1) begin miscompares++; $display("FAIL preload_bitb: got %b want 1", rf.BitOutB); end
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int a = 0; a < int'(REG_COUNT); a++) begin
      rf.RaddrA = 3'(a);
      rf.RaddrB = 3'(7 - a);
      @(negedge Clk);
      vectors++; if (rf.DataOutA !== 8'h00) begin miscompares++; $display("FAIL reset_a[%0d]: got %h want 00", a, rf.DataOutA); end
      vectors++; if (rf.DataOutB !== 8'h00) begin miscompares++; $display("FAIL reset_b[%0d]: got %h want 00", 7 - a, rf.DataOutB); end
      vectors++; if (rf.BitOutB !== 1'b0) begin miscompares++; $display("FAIL reset_bitb[%0d]: got %b want 0", 7 - a, rf.BitOutB); end
      vectors++; if (rf.ZeroFlag !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b want 0", rf.ZeroFlag); end
      tick();
    end
  endtask

  task automatic test_write_readback();
    wr(3'd5, 8'h3C);
    rf.RaddrA = 3'd5; rf.RaddrB = 3'd5;
    @(negedge Clk);
    vectors++; if (rf.DataOutA !== 8'h3C) begin miscompares++; $display("FAIL wr5_a: got %h want 3c", rf.DataOutA); end
    vectors++; if (rf.DataOutB !== 8'h3C) begin miscompares++; $display("FAIL wr5_b: got %h want 3c", rf.DataOutB); end
    vectors++; if (rf.BitOutB !== 1'b0) begin miscompares++; $display("FAIL wr5_bitb: got %b want 0", rf.BitOutB); end
    tick();
    wr(3'd2, 8'h01);
    rf.RaddrB = 3'd2;
    @(negedge Clk);
    vectors++; if (rf.DataOutB !== 8'h01) begin miscompares++; $display("FAIL wr2_b: got %h want 01", rf.DataOutB); end
    vectors++; if (rf.BitOutB !== 1'b1) begin miscompares++; $display("FAIL wr2_bitb: got %b want 1", rf.BitOutB); end
    tick();
  endtask

  task automatic test_hazard();
    wr(3'd3, 8'h10);
    rf.RaddrA  = 3'd3;
    rf.WriteEn = 1'b1; rf.Waddr = 3'd3; rf.DataIn = 8'h11;
    @(negedge Clk);
    vectors++; if (rf.DataOutA !== 8'h10) begin miscompares++; $display("FAIL hazard_old: got %h want 10", rf.DataOutA); end
    tick();
    rf.WriteEn = 1'b0;
    @(negedge Clk);
    vectors++; if (rf.DataOutA !== 8'h11) begin miscompares++; $display("FAIL hazard_new: got %h want 11", rf.DataOutA); end
    tick();
  endtask

  task automatic test_flag();
    rf.FlagWrite = 1'b1; rf.ZeroIn = 1'b1;
    tick();
    rf.FlagWrite = 1'b0; rf.ZeroIn = 1'b0;
    @(negedge Clk);
    vectors++; if (rf.ZeroFlag !== 1'b1) begin miscompares++; $display("FAIL flag_set: got %b want 1", rf.ZeroFlag); end
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge Clk);
      vectors++; if (rf.ZeroFlag !== 1'b1) begin miscompares++; $display("FAIL flag_hold[%0d]: got %b want 1", c, rf.ZeroFlag); end
    end
    tick();
    rf.FlagWrite = 1'b1; rf.ZeroIn = 1'b0;
    tick();
    rf.FlagWrite = 1'b0;
    @(negedge Clk);
    vectors++; if (rf.ZeroFlag !== 1'b0) begin miscompares++; $display("FAIL flag_clear: got %b want 0", rf.ZeroFlag); end
    tick();
  endtask

  task automatic test_reset_priority();
    wr(3'd4, 8'h77);
    rf.WriteEn = 1'b1; rf.Waddr = 3'd4; rf.DataIn = 8'hFF;
    rf.FlagWrite = 1'b1; rf.ZeroIn = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0; rf.WriteEn = 1'b0; rf.FlagWrite = 1'b0; rf.ZeroIn = 1'b0;
    rf.RaddrA = 3'd4; rf.RaddrB = 3'd5;
    @(negedge Clk);
    vectors++; if (rf.DataOutA !== 8'h00) begin miscompares++; $display("FAIL prio_reg4: got %h want 00", rf.DataOutA); end
    vectors++; if (rf.DataOutB !== 8'h00) begin miscompares++; $display("FAIL prio_reg5: got %h want 00", rf.DataOutB); end
    vectors++; if (rf.ZeroFlag !== 1'b0) begin miscompares++; $display("FAIL prio_flag: got %b want 0", rf.ZeroFlag); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb [8];
    bb = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h24, 8'hDB};
    rf.WriteEn = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rf.Waddr  = 3'(a);
      rf.DataIn = bb[a];
      tick();
    end
    rf.WriteEn = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rf.RaddrA = 3'(a);
      rf.RaddrB = 3'(7 - a);
      @(negedge Clk);
      vectors++; if (rf.DataOutA !== bb[a]) begin miscompares++; $display("FAIL b2b_a[%0d]: got %h want %h", a, rf.DataOutA, bb[a]); end
      vectors++; if (rf.DataOutB !== bb[7 - a]) begin miscompares++; $display("FAIL b2b_b[%0d]: got %h want %h", 7 - a, rf.DataOutB, bb[7 - a]); end
      vectors++; if (rf.BitOutB !== bb[7 - a][0]) begin miscompares++; $display("FAIL b2b_bitb[%0d]: got %b want %b", 7 - a, rf.BitOutB, bb[7 - a][0]); end
      tick();
    end
  endtask

  task automatic test_alu_loop();
    logic [7:0] exp_val [3];
    logic       exp_z   [3];
    exp_val = '{8'hFF, 8'h00, 8'h01};
    exp_z   = '{1'b0, 1'b1, 1'b0};
    wr(REG_LOOP, 8'hFE);
    rf.RaddrA = REG_LOOP;
    rf.RaddrB = REG_ACC;
    #1;
    for (int i = 0; i < 3; i++) begin
      rf.DataIn    = alu_model(ALU_INC, rf.DataOutA);
      rf.ZeroIn    = (rf.DataIn == 8'h00);
      rf.WriteEn   = 1'b1;
      rf.Waddr     = REG_LOOP;
      rf.FlagWrite = 1'b1;
      tick();
      @(negedge Clk);
      vectors++; if (rf.DataOutA !== exp_val[i]) begin miscompares++; $display("FAIL loop_val[%0d]: got %h want %h", i, rf.DataOutA, exp_val[i]); end
      vectors++; if (rf.ZeroFlag !== exp_z[i]) begin miscompares++; $display("FAIL loop_flag[%0d]: got %b want %b", i, rf.ZeroFlag, exp_z[i]); end
    end
    tick();
    rf.WriteEn = 1'b0; rf.FlagWrite = 1'b0; rf.ZeroIn = 1'b0;
  endtask

  initial begin
    rf.RaddrA = '0; rf.RaddrB = '0; rf.WriteEn = 1'b0; rf.Waddr = '0;
    rf.DataIn = '0; rf.FlagWrite = 1'b0; rf.ZeroIn = 1'b0;
    test_reset();
    test_write_readback();
    test_hazard();
    test_flag();
    test_reset_priority();
    test_back_to_back();
    test_alu_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
